// File: rtl/uart_rx.sv
// 8N1 serial receiver, LSB first: synchronizes the line, finds start edges,
// samples each bit at its centre and reports each byte or a framing error.
module uart_rx #(
  parameter real SYSCLOCK = 27.0,
  parameter real BAUDRATE = 1.0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_bsy
);

  localparam int CPB  = int'(SYSCLOCK / BAUDRATE);
  localparam int HALF = CPB / 2;
  localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;

  // Counter runs from 0, so the Nth cycle in a state sees the value N-1.
  localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CPB - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [CW-1:0]   cnt_r, cnt_nxt_s;
  logic [2:0]      idx_r, idx_nxt_s;
  logic [7:0]      shift_r, shift_nxt_s;
  logic [7:0]      data_nxt_s;
  logic            valid_nxt_s, ferr_nxt_s, bsy_nxt_s;
  logic            rx_meta, rx_s, rx_s_d;

  // Two-flop synchronizer plus one-cycle history for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  // Frame sequencing: next state, bit timing, shift register and output strobes.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
    idx_nxt_s   = idx_r;
    shift_nxt_s = shift_r;
    data_nxt_s  = rx_data;
    valid_nxt_s = 1'b0;
    ferr_nxt_s  = 1'b0;
    bsy_nxt_s   = rx_bsy;
    case (state_r)
      IDLE: begin
        cnt_nxt_s = {CW{1'b0}};
        // Only a true falling edge starts a frame; a line stuck low does not.
        if (!rx_s && rx_s_d) begin
          state_nxt_s = START;
          bsy_nxt_s   = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == HALF_END) begin
          if (rx_s) begin
            state_nxt_s = IDLE;
            bsy_nxt_s   = 1'b0;
          end else begin
            state_nxt_s = DATA;
            cnt_nxt_s   = {CW{1'b0}};
            idx_nxt_s   = 3'd0;
          end
        end else begin
          state_nxt_s = START;
        end
      end
      DATA: begin
        if (cnt_r == BIT_END) begin
          shift_nxt_s = {rx_s, shift_r[7:1]};
          cnt_nxt_s   = {CW{1'b0}};
          idx_nxt_s   = idx_r + 3'd1;
          if (idx_r == 3'd7) begin
            state_nxt_s = STOP;
          end else begin
            state_nxt_s = DATA;
          end
        end else begin
          state_nxt_s = DATA;
        end
      end
      STOP: begin
        // Leaving at mid stop bit lets a back-to-back start edge be caught.
        if (cnt_r == BIT_END) begin
          state_nxt_s = IDLE;
          bsy_nxt_s   = 1'b0;
          if (rx_s) begin
            data_nxt_s  = shift_r;
            valid_nxt_s = 1'b1;
          end else begin
            ferr_nxt_s  = 1'b1;
          end
        end else begin
          state_nxt_s = STOP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {CW{1'b0}};
        bsy_nxt_s   = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= {CW{1'b0}};
      idx_r        <= 3'd0;
      shift_r      <= 8'h00;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_bsy       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      idx_r        <= idx_nxt_s;
      shift_r      <= shift_nxt_s;
      rx_data      <= data_nxt_s;
      rx_valid     <= valid_nxt_s;
      rx_frame_err <= ferr_nxt_s;
      rx_bsy       <= bsy_nxt_s;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at the default 27 clocks per bit.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_bsy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_start = 0;

  int vq_cyc[$];
  int vq_data[$];
  int eq_cyc[$];
  int both_cnt = 0;
  int long_cnt = 0;
  int rise_cnt = 0;
  int bsy_rise = -1;
  int bsy_fall = -1;
  logic valid_d = 1'b0;
  logic ferr_d  = 1'b0;
  logic bsy_d   = 1'b0;

  uart_rx dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_bsy       (rx_bsy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record pulses and busy transitions, sampled mid-cycle.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      vq_cyc.push_back(cyc);
      vq_data.push_back(int'(rx_data));
    end
    if (rx_frame_err === 1'b1) eq_cyc.push_back(cyc);
    if (rx_valid === 1'b1 && rx_frame_err === 1'b1) both_cnt <= both_cnt + 1;
    if ((rx_valid === 1'b1 && valid_d) || (rx_frame_err === 1'b1 && ferr_d))
      long_cnt <= long_cnt + 1;
    if (rx_bsy === 1'b1 && !bsy_d) begin
      bsy_rise <= cyc;
      rise_cnt <= rise_cnt + 1;
    end
    if (rx_bsy === 1'b0 && bsy_d) bsy_fall <= cyc;
    valid_d <= (rx_valid === 1'b1);
    ferr_d  <= (rx_frame_err === 1'b1);
    bsy_d   <= (rx_bsy === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic int vcyc(input int i);
    return (i < vq_cyc.size()) ? vq_cyc[i] : -1;
  endfunction

  function automatic int vdat(input int i);
    return (i < vq_data.size()) ? vq_data[i] : -1;
  endfunction

  function automatic int ecyc(input int i);
    return (i < eq_cyc.size()) ? eq_cyc[i] : -1;
  endfunction

  // Called just after a rising edge; leaves the line at v for n clocks.
  task automatic drive_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int cpb, input logic stop);
    last_start = cyc;
    drive_bit(1'b0, cpb);
    for (int i = 0; i < 8; i++) drive_bit(b[i], cpb);
    drive_bit(stop, cpb);
  endtask

  // Sends one byte at 27 clk/bit and expects exactly it back.
  task automatic expect_byte(input string tag, input logic [7:0] b);
    int v0;
    int e0;
    v0 = vq_cyc.size();
    e0 = eq_cyc.size();
    send(b, 27, 1'b1);
    drive_bit(1'b1, 20);
    chk({tag, "_cnt"}, vq_cyc.size() - v0, 1);
    chk({tag, "_data"}, vdat(v0), int'(b));
    chk({tag, "_ferr"}, eq_cyc.size() - e0, 0);
  endtask

  int p, v0, e0, r0;
  int cpbs[3] = '{27, 26, 28};
  logic [7:0] b2b[3] = '{8'h00, 8'hFF, 8'h81};

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data",  rx_data, 8'h00);
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_ferr",  rx_frame_err, 1'b0);
    chk("rst_bsy",   rx_bsy, 1'b0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Nominal 0xA5: E is two clocks after the pin edge, valid at E+257.
    v0 = vq_cyc.size();
    e0 = eq_cyc.size();
    send(8'hA5, 27, 1'b1);
    p = last_start;
    drive_bit(1'b1, 20);
    chk("nom_cnt", vq_cyc.size() - v0, 1);
    chk("nom_cyc", vcyc(v0), p + 2 + 257);
    chk("nom_data", vdat(v0), 8'hA5);
    chk("nom_ferr", eq_cyc.size() - e0, 0);
    chk("nom_bsy_rise", bsy_rise, p + 2 + 1);
    chk("nom_bsy_fall", bsy_fall, p + 2 + 257);

    // 5-clock glitch: false start aborted at the mid-start sample.
    v0 = vq_cyc.size();
    e0 = eq_cyc.size();
    p = cyc;
    drive_bit(1'b0, 5);
    drive_bit(1'b1, 60);
    chk("gl_valid", vq_cyc.size() - v0, 0);
    chk("gl_ferr", eq_cyc.size() - e0, 0);
    chk("gl_bsy_rise", bsy_rise, p + 2 + 1);
    chk("gl_bsy_fall", bsy_fall, p + 2 + 14);
    expect_byte("gl_3c", 8'h3C);

    // Framing error followed by a 500-clock break.
    expect_byte("fe_11", 8'h11);
    v0 = vq_cyc.size();
    e0 = eq_cyc.size();
    r0 = rise_cnt;
    send(8'h55, 27, 1'b0);
    p = last_start;
    drive_bit(1'b0, 500);
    chk("fe_cnt", eq_cyc.size() - e0, 1);
    chk("fe_cyc", ecyc(e0), p + 2 + 257);
    chk("fe_valid", vq_cyc.size() - v0, 0);
    chk("fe_hold", rx_data, 8'h11);
    chk("fe_break_starts", rise_cnt - r0, 1);
    drive_bit(1'b1, 30);
    expect_byte("fe_96", 8'h96);

    // Back-to-back frames at nominal and skewed bit times.
    for (int k = 0; k < 3; k++) begin
      v0 = vq_cyc.size();
      e0 = eq_cyc.size();
      for (int j = 0; j < 3; j++) send(b2b[j], cpbs[k], 1'b1);
      drive_bit(1'b1, 40);
      chk($sformatf("b2b%0d_cnt", cpbs[k]), vq_cyc.size() - v0, 3);
      chk($sformatf("b2b%0d_ferr", cpbs[k]), eq_cyc.size() - e0, 0);
      for (int j = 0; j < 3; j++)
        chk($sformatf("b2b%0d_d%0d", cpbs[k], j), vdat(v0 + j), int'(b2b[j]));
      chk($sformatf("b2b%0d_gap1", cpbs[k]), vcyc(v0 + 1) - vcyc(v0), 10 * cpbs[k]);
      chk($sformatf("b2b%0d_gap2", cpbs[k]), vcyc(v0 + 2) - vcyc(v0 + 1), 10 * cpbs[k]);
    end

    // Reset held through cycle E+100 of a 0x5A frame.
    v0 = vq_cyc.size();
    e0 = eq_cyc.size();
    p = cyc;
    fork
      send(8'h5A, 27, 1'b1);
      begin
        repeat (102) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mr_cyc", cyc, p + 2 + 101);
        chk("mr_data", rx_data, 8'h00);
        chk("mr_valid", rx_valid, 1'b0);
        chk("mr_ferr", rx_frame_err, 1'b0);
        chk("mr_bsy", rx_bsy, 1'b0);
      end
    join
    chk("mr_nopulse", (vq_cyc.size() - v0) + (eq_cyc.size() - e0), 0);
    drive_bit(1'b1, 400);
    expect_byte("mr_c3", 8'hC3);

    chk("excl", both_cnt, 0);
    chk("pulse_width", long_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
